// File: rtl/mem_bridge_pkg.sv
// Shared types and constants for the mem_req_bridge request/response bridge.
// Holds the FSM state enum, the default-width request record and the statistics width.
package mem_bridge_pkg;

   localparam int DEF_ADDR_WIDTH = 8;
   localparam int DEF_DATA_WIDTH = 16;
   localparam int STAT_WIDTH     = 32;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      RD_WAIT = 2'd2
   } state_e;

   typedef struct packed {
      logic                      wr;
      logic [DEF_ADDR_WIDTH-1:0] addr;
      logic [DEF_DATA_WIDTH-1:0] wdata;
   } req_t;

endpackage

// File: rtl/mem_req_bridge_fifo.sv
// sync_fifo: single-clock show-ahead FIFO; head word is visible on o_pop_data whenever not empty.
// Push is ignored when full and pop is ignored when empty; o_count is the registered occupancy.
module sync_fifo
   import mem_bridge_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_push_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_pop_data,
   output logic             o_full,
   output logic             o_empty,
   output logic [CNT_W-1:0] o_count
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full     = (r_count == CNT_W'(DEPTH));
   assign o_empty    = (r_count == '0);
   assign o_count    = r_count;
   assign o_pop_data = r_mem[r_rd_ptr];

   assign w_push = i_push & ~o_full;
   assign w_pop  = i_pop & ~o_empty;

   // Storage carries no reset; validity is tracked purely by the pointers and count.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/mem_req_bridge.sv
// mem_req_bridge: queues read/write requests, issues them one at a time to a single-port memory
// and returns credit-limited read data in order. Optional counters: MEM_REQ_BRIDGE_STATS_EN.
module mem_req_bridge
   import mem_bridge_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 16,
   parameter int REQ_DEPTH  = 4,
   parameter int RSP_DEPTH  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_vld_i,
   output logic                  req_rdy_o,
   input  logic                  req_wr_i,
   input  logic [ADDR_WIDTH-1:0] req_addr_i,
   input  logic [DATA_WIDTH-1:0] req_wdata_i,
   output logic                  mem_vld_o,
   output logic                  mem_wr_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   input  logic                  mem_rdy_i,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i,
   output logic                  rsp_vld_o,
   input  logic                  rsp_rdy_i,
   output logic [DATA_WIDTH-1:0] rsp_data_o,
   output logic                  busy_o
`ifdef MEM_REQ_BRIDGE_STATS_EN
   ,
   output logic [STAT_WIDTH-1:0] wr_cnt_o,
   output logic [STAT_WIDTH-1:0] rd_cnt_o
`endif
);

   localparam int REQ_W     = 1 + ADDR_WIDTH + DATA_WIDTH;
   localparam int REQ_CNT_W = $clog2(REQ_DEPTH) + 1;
   localparam int RSP_CNT_W = $clog2(RSP_DEPTH) + 1;

   state_e                 r_state;
   state_e                 w_state_next;

   logic                   w_req_push;
   logic                   w_req_full;
   logic                   w_req_empty;
   logic [REQ_CNT_W-1:0]   w_req_count;
   logic [REQ_W-1:0]       w_req_in;
   logic [REQ_W-1:0]       w_req_head;
   logic                   w_req_nonempty_next;

   logic                   w_head_wr;
   logic                   w_rd_pending;
   logic                   w_credit;
   logic                   w_mem_vld;
   logic                   w_mem_acc;
   logic                   w_rd_acc;

   logic                   w_rsp_push;
   logic                   w_rsp_pop;
   logic                   w_rsp_full;
   logic                   w_rsp_empty;
   logic [RSP_CNT_W-1:0]   w_rsp_count;

   // ---------------- request queue ----------------
   assign w_req_push = req_vld_i & req_rdy_o;
   assign w_req_in   = {req_wr_i, req_addr_i, req_wdata_i};
   assign req_rdy_o  = ~w_req_full;

   sync_fifo #(
      .WIDTH (REQ_W),
      .DEPTH (REQ_DEPTH)
   ) u_req_fifo (
      .clk         (clk),
      .rst         (rst),
      .i_push      (w_req_push),
      .i_push_data (w_req_in),
      .i_pop       (w_mem_acc),
      .o_pop_data  (w_req_head),
      .o_full      (w_req_full),
      .o_empty     (w_req_empty),
      .o_count     (w_req_count)
   );

   assign w_head_wr = w_req_head[REQ_W-1];

   // Occupancy after this edge; lets IDLE hand over to ISSUE in the same cycle as the push.
   assign w_req_nonempty_next = w_req_push |
                                (~w_req_empty & ~(w_mem_acc & (w_req_count == REQ_CNT_W'(1))));

   // ---------------- issue side ----------------
   assign w_rd_pending = (r_state == RD_WAIT);
   assign w_credit     = (w_rsp_count + {{(RSP_CNT_W-1){1'b0}}, w_rd_pending})
                         < RSP_CNT_W'(RSP_DEPTH);
   assign w_mem_vld    = (r_state == ISSUE) & ~w_req_empty & (w_head_wr | w_credit);
   assign w_mem_acc    = w_mem_vld & mem_rdy_i;
   assign w_rd_acc     = w_mem_acc & ~w_head_wr;

   assign mem_vld_o   = w_mem_vld;
   assign mem_wr_o    = w_head_wr;
   assign mem_addr_o  = w_req_head[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
   assign mem_wdata_o = w_req_head[DATA_WIDTH-1:0];

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_req_nonempty_next) begin
               w_state_next = ISSUE;
            end
         end
         ISSUE: begin
            if (w_rd_acc) begin
               w_state_next = RD_WAIT;
            end else if (!w_req_nonempty_next) begin
               w_state_next = IDLE;
            end
         end
         RD_WAIT: begin
            w_state_next = w_req_nonempty_next ? ISSUE : IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ---------------- response queue ----------------
   // Credit guarantees a free slot in RD_WAIT; the full check is only a safety net.
   assign w_rsp_push = (r_state == RD_WAIT) & ~w_rsp_full;
   assign w_rsp_pop  = rsp_vld_o & rsp_rdy_i;
   assign rsp_vld_o  = ~w_rsp_empty;

   sync_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (RSP_DEPTH)
   ) u_rsp_fifo (
      .clk         (clk),
      .rst         (rst),
      .i_push      (w_rsp_push),
      .i_push_data (mem_rdata_i),
      .i_pop       (w_rsp_pop),
      .o_pop_data  (rsp_data_o),
      .o_full      (w_rsp_full),
      .o_empty     (w_rsp_empty),
      .o_count     (w_rsp_count)
   );

   assign busy_o = ~w_req_empty | (r_state == RD_WAIT) | ~w_rsp_empty;

`ifdef MEM_REQ_BRIDGE_STATS_EN
   logic [STAT_WIDTH-1:0] r_wr_cnt;
   logic [STAT_WIDTH-1:0] r_rd_cnt;

   // Saturating counters of accepted memory transactions.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_cnt <= '0;
         r_rd_cnt <= '0;
      end else begin
         if (w_mem_acc && w_head_wr && !(&r_wr_cnt)) begin
            r_wr_cnt <= r_wr_cnt + STAT_WIDTH'(1);
         end
         if (w_rd_acc && !(&r_rd_cnt)) begin
            r_rd_cnt <= r_rd_cnt + STAT_WIDTH'(1);
         end
      end
   end

   assign wr_cnt_o = r_wr_cnt;
   assign rd_cnt_o = r_rd_cnt;
`endif

endmodule

// File: tb/tb_mem_req_bridge.sv
// Bench for mem_req_bridge: directed scenarios plus a randomized run against a request-order model.
// Build with MEM_REQ_BRIDGE_STATS_EN defined to also exercise the transaction counters.
module tb_mem_req_bridge;
   import mem_bridge_pkg::*;

   localparam int ADDR_WIDTH = 8;
   localparam int DATA_WIDTH = 16;
   localparam int REQ_DEPTH  = 4;
   localparam int RSP_DEPTH  = 2;

   logic                  clk;
   logic                  rst;
   logic                  req_vld_i;
   logic                  req_rdy_o;
   logic                  req_wr_i;
   logic [ADDR_WIDTH-1:0] req_addr_i;
   logic [DATA_WIDTH-1:0] req_wdata_i;
   logic                  mem_vld_o;
   logic                  mem_wr_o;
   logic [ADDR_WIDTH-1:0] mem_addr_o;
   logic [DATA_WIDTH-1:0] mem_wdata_o;
   logic                  mem_rdy_i;
   logic [DATA_WIDTH-1:0] mem_rdata_i;
   logic                  rsp_vld_o;
   logic                  rsp_rdy_i;
   logic [DATA_WIDTH-1:0] rsp_data_o;
   logic                  busy_o;
`ifdef MEM_REQ_BRIDGE_STATS_EN
   logic [STAT_WIDTH-1:0] wr_cnt_o;
   logic [STAT_WIDTH-1:0] rd_cnt_o;
`endif

   mem_req_bridge #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .REQ_DEPTH  (REQ_DEPTH),
      .RSP_DEPTH  (RSP_DEPTH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_vld_i   (req_vld_i),
      .req_rdy_o   (req_rdy_o),
      .req_wr_i    (req_wr_i),
      .req_addr_i  (req_addr_i),
      .req_wdata_i (req_wdata_i),
      .mem_vld_o   (mem_vld_o),
      .mem_wr_o    (mem_wr_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_rdy_i   (mem_rdy_i),
      .mem_rdata_i (mem_rdata_i),
      .rsp_vld_o   (rsp_vld_o),
      .rsp_rdy_i   (rsp_rdy_i),
      .rsp_data_o  (rsp_data_o),
      .busy_o      (busy_o)
`ifdef MEM_REQ_BRIDGE_STATS_EN
      ,
      .wr_cnt_o    (wr_cnt_o),
      .rd_cnt_o    (rd_cnt_o)
`endif
   );

   int n_vec = 0;
   int n_err = 0;

   // Memory environment (contents change in issue order) and golden image (request order).
   logic [DATA_WIDTH-1:0] tbmem [256];
   logic [DATA_WIDTH-1:0] gold  [256];
   req_t                  exp_iss[$];
   logic [DATA_WIDTH-1:0] exp_rsp[$];
   bit                    mem_rdy_rand = 1'b0;
   bit                    rd_pending   = 1'b0;
   logic [ADDR_WIDTH-1:0] rd_addr;
   int                    req_cnt_m    = 0;
   int                    avail_m      = 0;
   int                    outstanding  = 0;
   bit                    acc_m1       = 1'b0;
   bit                    acc_m2       = 1'b0;
   bit                    prev_mhold   = 1'b0;
   bit                    prev_rhold   = 1'b0;
   req_t                  prev_mreq;
   logic [DATA_WIDTH-1:0] prev_rdata;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory responder plus cycle-by-cycle scoreboard, sampled 1 time unit before each rising edge.
   initial begin : monitor
      req_t                  cur;
      req_t                  e;
      logic [DATA_WIDTH-1:0] d;
      bit                    mem_acc;
      bit                    rsp_pop;
      bit                    req_push;
      for (int i = 0; i < 256; i++) begin
         tbmem[i] = 16'(i * 257) ^ 16'h5A5A;
         gold[i]  = tbmem[i];
      end
      forever begin
         @(negedge clk);
         mem_rdata_i = rd_pending ? tbmem[rd_addr] : 16'($urandom);
         rd_pending  = 1'b0;
         mem_rdy_i   = mem_rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
         #4;
         mem_acc = (mem_vld_o === 1'b1) && (mem_rdy_i === 1'b1);
         cur = '{wr: mem_wr_o, addr: mem_addr_o, wdata: mem_wdata_o};
         if (mem_acc) begin
            if (cur.wr) tbmem[cur.addr] = cur.wdata;
            else begin
               rd_pending = 1'b1;
               rd_addr    = cur.addr;
            end
         end
         if (rst) begin
            exp_iss.delete();
            exp_rsp.delete();
            req_cnt_m = 0; avail_m = 0; outstanding = 0;
            acc_m1 = 1'b0; acc_m2 = 1'b0; prev_mhold = 1'b0; prev_rhold = 1'b0;
            for (int i = 0; i < 256; i++) gold[i] = tbmem[i];
         end else begin
            if (acc_m2) avail_m++;
            n_vec++;
            if (req_rdy_o !== (req_cnt_m < REQ_DEPTH)) begin
               n_err++;
               $display("FAIL mon_req_rdy: got %b expected %b (queued %0d)", req_rdy_o, req_cnt_m < REQ_DEPTH, req_cnt_m);
            end
            n_vec++;
            if (rsp_vld_o !== (avail_m > 0)) begin
               n_err++;
               $display("FAIL mon_rsp_vld: got %b expected %b", rsp_vld_o, avail_m > 0);
            end
            n_vec++;
            if (busy_o !== ((req_cnt_m > 0) || acc_m1 || (avail_m > 0))) begin
               n_err++;
               $display("FAIL mon_busy: got %b expected %b", busy_o, (req_cnt_m > 0) || acc_m1 || (avail_m > 0));
            end
            n_vec++;
            if (mem_vld_o === 1'b1 && req_cnt_m == 0) begin
               n_err++;
               $display("FAIL mon_bypass: mem_vld_o got 1 expected 0 with empty request queue");
            end
            if (prev_mhold) begin
               n_vec++;
               if (mem_vld_o !== 1'b1 || cur !== prev_mreq) begin
                  n_err++;
                  $display("FAIL mon_mem_hold: got vld=%b req=%h expected vld=1 req=%h", mem_vld_o, cur, prev_mreq);
               end
            end
            if (prev_rhold) begin
               n_vec++;
               if (rsp_vld_o !== 1'b1 || rsp_data_o !== prev_rdata) begin
                  n_err++;
                  $display("FAIL mon_rsp_hold: got vld=%b data=%h expected vld=1 data=%h", rsp_vld_o, rsp_data_o, prev_rdata);
               end
            end
            if (mem_acc) begin
               n_vec++;
               if (exp_iss.size() == 0) begin
                  n_err++;
                  $display("FAIL mon_mem_req: got req=%h expected no request", cur);
               end else begin
                  e = exp_iss.pop_front();
                  if (cur.wr !== e.wr || cur.addr !== e.addr || (e.wr && cur.wdata !== e.wdata)) begin
                     n_err++;
                     $display("FAIL mon_mem_req: got req=%h expected %h", cur, e);
                  end
               end
               if (!cur.wr) begin
                  n_vec++;
                  if (outstanding >= RSP_DEPTH) begin
                     n_err++;
                     $display("FAIL mon_credit: got %0d reads outstanding expected below %0d", outstanding, RSP_DEPTH);
                  end
                  outstanding++;
               end
            end
            rsp_pop = (rsp_vld_o === 1'b1) && (rsp_rdy_i === 1'b1);
            if (rsp_pop) begin
               n_vec++;
               if (exp_rsp.size() == 0) begin
                  n_err++;
                  $display("FAIL mon_rsp_data: got %h expected no response", rsp_data_o);
               end else begin
                  d = exp_rsp.pop_front();
                  if (rsp_data_o !== d) begin
                     n_err++;
                     $display("FAIL mon_rsp_data: got %h expected %h", rsp_data_o, d);
                  end
               end
               if (avail_m > 0) avail_m--;
               if (outstanding > 0) outstanding--;
            end
            req_push = (req_vld_i === 1'b1) && (req_rdy_o === 1'b1);
            if (req_push) begin
               e = '{wr: req_wr_i, addr: req_addr_i, wdata: req_wdata_i};
               exp_iss.push_back(e);
               if (req_wr_i) gold[req_addr_i] = req_wdata_i;
               else exp_rsp.push_back(gold[req_addr_i]);
            end
            req_cnt_m  = req_cnt_m + int'(req_push) - int'(mem_acc);
            acc_m2     = acc_m1;
            acc_m1     = mem_acc && !cur.wr;
            prev_mhold = (mem_vld_o === 1'b1) && (mem_rdy_i !== 1'b1);
            prev_mreq  = cur;
            prev_rhold = (rsp_vld_o === 1'b1) && (rsp_rdy_i !== 1'b1);
            prev_rdata = rsp_data_o;
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst       = 1'b1;
      req_vld_i = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      #4;
      n_vec++;
      if (req_rdy_o !== 1'b1) begin n_err++; $display("FAIL reset_req_rdy: got %b expected 1", req_rdy_o); end
      n_vec++;
      if (mem_vld_o !== 1'b0) begin n_err++; $display("FAIL reset_mem_vld: got %b expected 0", mem_vld_o); end
      n_vec++;
      if (rsp_vld_o !== 1'b0) begin n_err++; $display("FAIL reset_rsp_vld: got %b expected 0", rsp_vld_o); end
      n_vec++;
      if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
      $display("test_reset done");
   endtask

   task automatic test_write_read();
      int n_acc = 0, wr_cyc = -1, rd_cyc = -1, rsp_cyc = -1;
      logic [DATA_WIDTH-1:0] rsp_d = '0;
      do_reset();
      rsp_rdy_i = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         req_vld_i   = (c < 2);
         req_wr_i    = (c == 0);
         req_addr_i  = 8'h10;
         req_wdata_i = (c == 0) ? 16'hBEEF : 16'h0000;
         #4;
         if (mem_vld_o === 1'b1 && mem_rdy_i === 1'b1) begin
            if (n_acc == 0) begin
               wr_cyc = c;
               n_vec++;
               if (mem_wr_o !== 1'b1 || mem_addr_o !== 8'h10 || mem_wdata_o !== 16'hBEEF) begin
                  n_err++;
                  $display("FAIL wr_rd_first: got wr=%b addr=%h data=%h expected wr=1 addr=10 data=beef", mem_wr_o, mem_addr_o, mem_wdata_o);
               end
            end else if (n_acc == 1) begin
               rd_cyc = c;
               n_vec++;
               if (mem_wr_o !== 1'b0 || mem_addr_o !== 8'h10) begin
                  n_err++;
                  $display("FAIL wr_rd_second: got wr=%b addr=%h expected wr=0 addr=10", mem_wr_o, mem_addr_o);
               end
            end
            n_acc++;
         end
         if (rsp_vld_o === 1'b1 && rsp_cyc < 0) begin
            rsp_cyc = c;
            rsp_d   = rsp_data_o;
         end
      end
      n_vec++;
      if (n_acc != 2 || wr_cyc < 1) begin n_err++; $display("FAIL wr_rd_issue: got %0d accepts first at cycle %0d expected 2 accepts from cycle 1", n_acc, wr_cyc); end
      n_vec++;
      if (rd_cyc < 0 || rsp_cyc != rd_cyc + 2) begin n_err++; $display("FAIL wr_rd_latency: got rsp at cycle %0d expected %0d", rsp_cyc, rd_cyc + 2); end
      n_vec++;
      if (rsp_d !== 16'hBEEF) begin n_err++; $display("FAIL wr_rd_data: got %h expected beef", rsp_d); end
      n_vec++;
      if (busy_o !== 1'b0) begin n_err++; $display("FAIL wr_rd_busy: got %b expected 0", busy_o); end
      $display("test_write_read done: write@%0d read@%0d rsp@%0d data=%h", wr_cyc, rd_cyc, rsp_cyc, rsp_d);
   endtask

   task automatic test_back_to_back();
      int n_acc = 0, first = -1;
      bit rsp_seen = 1'b0;
      do_reset();
      rsp_rdy_i = 1'b1;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         req_vld_i   = (c < 4);
         req_wr_i    = 1'b1;
         req_addr_i  = 8'(c);
         req_wdata_i = 16'h1000 + 16'(c);
         #4;
         if (rsp_vld_o !== 1'b0) rsp_seen = 1'b1;
         if (mem_vld_o === 1'b1 && mem_rdy_i === 1'b1) begin
            if (n_acc == 0) first = c;
            n_vec++;
            if (c != first + n_acc || mem_wr_o !== 1'b1 || mem_addr_o !== 8'(n_acc) || mem_wdata_o !== 16'h1000 + 16'(n_acc)) begin
               n_err++;
               $display("FAIL b2b_write%0d: got cyc=%0d wr=%b addr=%h data=%h expected cyc=%0d wr=1 addr=%h data=%h",
                        n_acc, c, mem_wr_o, mem_addr_o, mem_wdata_o, first + n_acc, 8'(n_acc), 16'h1000 + 16'(n_acc));
            end
            n_acc++;
         end
      end
      n_vec++;
      if (n_acc != 4) begin n_err++; $display("FAIL b2b_count: got %0d writes expected 4", n_acc); end
      n_vec++;
      if (rsp_seen) begin n_err++; $display("FAIL b2b_no_rsp: got rsp_vld_o=1 expected 0"); end
      $display("test_back_to_back done: %0d writes from cycle %0d", n_acc, first);
   endtask

   task automatic test_credit();
      int pushed = 0, rd_acc = 0, got = 0;
      bit stop = 1'b0;
      rsp_rdy_i = 1'b0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (!stop && req_rdy_o === 1'b1) begin
            req_vld_i  = 1'b1;
            req_wr_i   = 1'b0;
            req_addr_i = 8'(pushed % 4);
            pushed++;
         end else begin
            if (req_rdy_o !== 1'b1) stop = 1'b1;
            req_vld_i = 1'b0;
         end
         #4;
         if (mem_vld_o === 1'b1 && mem_rdy_i === 1'b1) rd_acc++;
      end
      n_vec++;
      if (rd_acc != RSP_DEPTH) begin n_err++; $display("FAIL credit_reads: got %0d reads issued expected %0d", rd_acc, RSP_DEPTH); end
      n_vec++;
      if (pushed != REQ_DEPTH + RSP_DEPTH || req_rdy_o !== 1'b0) begin
         n_err++;
         $display("FAIL credit_full: got %0d pushed rdy=%b expected %0d pushed rdy=0", pushed, req_rdy_o, REQ_DEPTH + RSP_DEPTH);
      end
      @(negedge clk);
      rsp_rdy_i = 1'b1;
      for (int c = 0; c < 60; c++) begin
         #4;
         if (rsp_vld_o === 1'b1) begin
            n_vec++;
            if (rsp_data_o !== 16'h1000 + 16'(got % 4)) begin
               n_err++;
               $display("FAIL credit_data%0d: got %h expected %h", got, rsp_data_o, 16'h1000 + 16'(got % 4));
            end
            got++;
         end
         @(negedge clk);
      end
      n_vec++;
      if (got != pushed || busy_o !== 1'b0) begin n_err++; $display("FAIL credit_drain: got %0d responses busy=%b expected %0d busy=0", got, busy_o, pushed); end
      $display("test_credit done: %0d pushed, %0d issued under backpressure, %0d returned", pushed, rd_acc, got);
   endtask

   task automatic test_wr_rd_order();
      int got = 0;
      logic [DATA_WIDTH-1:0] d = '0;
      rsp_rdy_i = 1'b1;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         req_vld_i   = (c < 2);
         req_wr_i    = (c == 0);
         req_addr_i  = 8'h20;
         req_wdata_i = 16'h1234;
         #4;
         if (rsp_vld_o === 1'b1) begin
            got++;
            d = rsp_data_o;
         end
      end
      n_vec++;
      if (got != 1 || d !== 16'h1234) begin n_err++; $display("FAIL order_data: got %0d rsp data=%h expected 1 rsp data=1234", got, d); end
      $display("test_wr_rd_order done: data=%h", d);
   endtask

   task automatic test_reset_rd_wait();
      bit found = 1'b0;
      bit stray = 1'b0;
      do_reset();
      rsp_rdy_i = 1'b1;
      for (int c = 0; c < 10 && !found; c++) begin
         @(negedge clk);
         req_vld_i   = (c < 2);
         req_wr_i    = (c == 1);
         req_addr_i  = (c == 0) ? 8'h05 : 8'h06;
         req_wdata_i = 16'hAAAA;
         #4;
         if (mem_vld_o === 1'b1 && mem_rdy_i === 1'b1 && mem_wr_o === 1'b0) found = 1'b1;
      end
      n_vec++;
      if (!found) begin n_err++; $display("FAIL rst_rdwait_issue: got no read accept expected one within 10 cycles"); end
      @(negedge clk);
      req_vld_i = 1'b0;
      rst       = 1'b1;
      #4;
      n_vec++;
      if (busy_o !== 1'b1 || mem_vld_o !== 1'b0) begin n_err++; $display("FAIL rst_rdwait_state: got busy=%b vld=%b expected busy=1 vld=0", busy_o, mem_vld_o); end
      @(negedge clk);
      rst = 1'b0;
      #4;
      n_vec++;
      if (rsp_vld_o !== 1'b0 || mem_vld_o !== 1'b0 || req_rdy_o !== 1'b1 || busy_o !== 1'b0) begin
         n_err++;
         $display("FAIL rst_rdwait_after: got rsp=%b mem=%b rdy=%b busy=%b expected 0 0 1 0", rsp_vld_o, mem_vld_o, req_rdy_o, busy_o);
      end
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         #4;
         if (rsp_vld_o !== 1'b0 || mem_vld_o !== 1'b0) stray = 1'b1;
      end
      n_vec++;
      if (stray) begin n_err++; $display("FAIL rst_rdwait_stray: got activity after reset expected none"); end
      $display("test_reset_rd_wait done");
   endtask

   task automatic test_random();
      int drain = 0;
      do_reset();
      mem_rdy_rand = 1'b1;
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         req_vld_i   = ($urandom_range(0, 1) == 1);
         req_wr_i    = ($urandom_range(0, 1) == 1);
         req_addr_i  = 8'($urandom_range(0, 15));
         req_wdata_i = 16'($urandom);
         rsp_rdy_i   = ($urandom_range(0, 3) != 0);
      end
      @(negedge clk);
      req_vld_i = 1'b0;
      rsp_rdy_i = 1'b1;
      while (drain < 200) begin
         #4;
         if (busy_o === 1'b0) break;
         @(negedge clk);
         drain++;
      end
      mem_rdy_rand = 1'b0;
      n_vec++;
      if (busy_o !== 1'b0 || exp_iss.size() != 0 || exp_rsp.size() != 0) begin
         n_err++;
         $display("FAIL random_drain: got busy=%b %0d reqs %0d rsps left expected idle and none left", busy_o, exp_iss.size(), exp_rsp.size());
      end
      $display("test_random done: drained in %0d cycles", drain);
   endtask

`ifdef MEM_REQ_BRIDGE_STATS_EN
   task automatic test_stats();
      do_reset();
      rsp_rdy_i = 1'b1;
      for (int c = 0; c < 25; c++) begin
         @(negedge clk);
         req_vld_i   = (c < 5);
         req_wr_i    = (c < 3);
         req_addr_i  = 8'(c);
         req_wdata_i = 16'h7700 + 16'(c);
      end
      #4;
      n_vec++;
      if (wr_cnt_o !== 32'd3) begin n_err++; $display("FAIL stats_wr: got %0d expected 3", wr_cnt_o); end
      n_vec++;
      if (rd_cnt_o !== 32'd2) begin n_err++; $display("FAIL stats_rd: got %0d expected 2", rd_cnt_o); end
      do_reset();
      #4;
      n_vec++;
      if (wr_cnt_o !== 32'd0 || rd_cnt_o !== 32'd0) begin n_err++; $display("FAIL stats_clear: got wr=%0d rd=%0d expected 0 0", wr_cnt_o, rd_cnt_o); end
      $display("test_stats done");
   endtask
`endif

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got no completion expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst         = 1'b1;
      req_vld_i   = 1'b0;
      req_wr_i    = 1'b0;
      req_addr_i  = '0;
      req_wdata_i = '0;
      rsp_rdy_i   = 1'b1;
      mem_rdy_i   = 1'b1;
      mem_rdata_i = '0;
      test_reset();
      test_write_read();
      test_back_to_back();
      test_credit();
      test_wr_rd_order();
      test_reset_rd_wait();
      test_random();
`ifdef MEM_REQ_BRIDGE_STATS_EN
      test_stats();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mem_req_bridge.md
Name: mem_req_bridge

Overview:
- Upstream command stage that feeds the single-port memory block.
- Buffers incoming read/write requests in a request FIFO and issues them one at a time on the memory's vld/rdy interface.
- Captures the memory's one-cycle-late read data into a response FIFO and returns it in order on a vld/rdy response stream.
- Credit-limits reads so a response is never dropped under backpressure.

Parameters:
- ADDR_WIDTH, 8, memory address width.
- DATA_WIDTH, 16, data width.
- REQ_DEPTH, 4, request FIFO entries (power of 2, >=2).
- RSP_DEPTH, 2, response FIFO entries (power of 2, >=2); also the read credit limit.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- req_vld_i  in  1  request valid.
- req_rdy_o  out  1  request ready.
- req_wr_i  in  1  1=write, 0=read.
- req_addr_i  in  ADDR_WIDTH  request address.
- req_wdata_i  in  DATA_WIDTH  write data.
- mem_vld_o  out  1  memory request valid.
- mem_wr_o  out  1  memory write strobe.
- mem_addr_o  out  ADDR_WIDTH  memory address.
- mem_wdata_o  out  DATA_WIDTH  memory write data.
- mem_rdy_i  in  1  memory ready.
- mem_rdata_i  in  DATA_WIDTH  memory read data; valid the cycle after read acceptance.
- rsp_vld_o  out  1  read response valid.
- rsp_rdy_i  in  1  read response ready.
- rsp_data_o  out  DATA_WIDTH  read response data.
- busy_o  out  1  any request queued, read in flight, or response held.

Behaviour:
- Reset (rst=1 at a clock edge):
  - FIFOs empty, counters zero, FSM in IDLE, captured-data path cleared.
  - Outputs after reset: req_rdy_o=1, mem_vld_o=0, rsp_vld_o=0, busy_o=0.
  - Reset mid-operation discards all queued requests, any pending read capture and all held responses. No stray response after reset.
- Request side:
  - Push when req_vld_i & req_rdy_o.
  - req_rdy_o = request FIFO not full. It comes from registered occupancy and does not depend on a same-cycle pop.
  - No bypass: a request accepted in cycle N drives mem_vld_o at the earliest in cycle N+1.
- FSM states:
  - IDLE: request FIFO empty and no capture pending.
  - ISSUE: FIFO head presented to memory.
  - RD_WAIT: one cycle after a read is accepted; capture mem_rdata_i.
- Transitions:
  - IDLE -> ISSUE when the FIFO becomes non-empty.
  - ISSUE -> RD_WAIT when a read is accepted.
  - ISSUE -> ISSUE when a write is accepted and the FIFO still holds entries; otherwise ISSUE -> IDLE.
  - RD_WAIT -> ISSUE if the FIFO is non-empty, else IDLE.
- Issue rules:
  - In ISSUE, mem_vld_o = 1 if the head is a write, or if the head is a read and credit is available.
  - Credit is available when rsp_count + pending_read < RSP_DEPTH.
  - mem_wr_o, mem_addr_o and mem_wdata_o come from the head and are held stable while mem_vld_o=1 until mem_rdy_i=1.
  - The head is popped on mem_vld_o & mem_rdy_i.
  - mem_vld_o=0 in IDLE and RD_WAIT.
  - Once asserted, mem_vld_o never drops before acceptance. Credits only increase while a read waits.
- Writes:
  - Accepted back-to-back, one per cycle while mem_rdy_i=1.
  - Writes produce no response.
- Reads:
  - A read accepted in cycle M is captured at the end of M+1 (RD_WAIT).
  - rsp_vld_o rises in M+2.
- Responses:
  - Delivered in issue order.
  - Pop on rsp_vld_o & rsp_rdy_i.
  - rsp_data_o is stable while rsp_vld_o=1 and rsp_rdy_i=0.
- Simultaneous events:
  - A response pop and a capture in the same cycle keep rsp_count unchanged.
  - A request push and a memory pop in the same cycle keep the request count unchanged.
- busy_o = request FIFO non-empty | state==RD_WAIT | response FIFO non-empty.

Optional Feature:
- MEM_REQ_BRIDGE_STATS_EN defined:
  - Adds outputs wr_cnt_o and rd_cnt_o, each 32 bits.
  - They count accepted memory writes and reads, saturate at all-ones, and clear on rst.
- Undefined: these ports and counters do not exist.

Decomposition:
- mem_bridge_pkg holds:
  - the FSM state enum (IDLE, ISSUE, RD_WAIT);
  - a packed request struct (wr, addr, wdata) parameterised by the default widths;
  - constant STAT_WIDTH=32.
- Sub-module sync_fifo (parameters WIDTH and DEPTH; push/pop, full/empty, count), instantiated twice: request FIFO and response FIFO.

Test Plan:
- After reset, write 0x10<=0xBEEF then read 0x10 -> mem_vld_o asserted with mem_wr_o=1 then 0; rsp_data_o=0xBEEF with rsp_vld_o high exactly 2 cycles after the read acceptance; busy_o falls afterwards.
- Four back-to-back writes, addr 0..3, data 0x1000+i, mem_rdy_i=1 -> mem_vld_o high on 4 consecutive cycles in order; rsp_vld_o stays 0.
- rsp_rdy_i=0, push reads of addr 0..3 -> only 2 reads reach memory; req_rdy_o drops once the request FIFO is full. Then set rsp_rdy_i=1 -> data 0x1000..0x1003 returned in order with no loss or duplication.
- Write 0x20<=0x1234 immediately followed by read 0x20 -> response 0x1234 (no reordering).
- Assert rst during RD_WAIT -> next cycle rsp_vld_o=0, mem_vld_o=0, req_rdy_o=1; no response appears afterwards.
- With MEM_REQ_BRIDGE_STATS_EN: 3 writes + 2 reads -> wr_cnt_o=3, rd_cnt_o=2; both read 0 after rst.
